segment_history: RTL and testbench

//  Per-zone, per-station bx history buffer for converted segments.

---
 rtl/segment_history.sv | 199 +++++++++++++++++++
 tb/tb_segment_history.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/segment_history.sv
// -----------------------------------------------------------------------------
// segment_history
//    Per-zone, per-station bunch-crossing history buffer for converted
//    segments. It captures phi, theta, valid and CLCT pattern of the zone's
//    chambers once per bx_en strobe. It presents the last max_drift crossings
//    as [history][chamber][segment] arrays, with index 0 as the newest.
//
// Optional feature (macro SEG_HIST_DUP_SUPPRESS_EN):
//    When defined, an incoming valid segment is stored as invalid if the
//    newest stored slot already holds a valid segment in the same chamber
//    with identical phi and pattern. dup_flag then reports that suppression
//    for one output update. When undefined, inputs are stored as-is and
//    dup_flag stays 0.
//
// Ports:
//    clk       core clock
//    rst       asynchronous active-high reset (clears history and outputs)
//    bx_en     write strobe, one pulse per bunch crossing
//    flush     synchronous history clear; it wins over a same-cycle bx_en
//    ph_in     segment phi            [zone_cham][seg_ch]
//    ph_v_in   segment valid flags    [zone_cham] x seg_ch bits
//    th_in     theta values           [zone_cham][zone_seg]
//    cpat_in   CLCT patterns          [zone_cham][seg_ch]
//    ph_seg    history phi            [max_drift][zone_cham][seg_ch]
//    ph_seg_v  history valid          [max_drift][zone_cham] x seg_ch bits
//    th_seg    history theta          [max_drift][zone_cham][zone_seg]
//    cpat_seg  history pattern        [max_drift][zone_cham][seg_ch]
//    hist_full max_drift crossings written since reset/flush
//    dup_flag  duplicate suppressed on the last write [zone_cham] x seg_ch bits
// -----------------------------------------------------------------------------
module segment_history #(
   parameter int max_drift = 3,
   parameter int zone_cham = 6,
   parameter int seg_ch    = 2,
   parameter int zone_seg  = 2,
   parameter int bw_fph    = 13,
   parameter int bw_th     = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bx_en,
   input  logic              flush,
   input  logic [bw_fph-1:0] ph_in    [zone_cham-1:0][seg_ch-1:0],
   input  logic [seg_ch-1:0] ph_v_in  [zone_cham-1:0],
   input  logic [bw_th-1:0]  th_in    [zone_cham-1:0][zone_seg-1:0],
   input  logic [3:0]        cpat_in  [zone_cham-1:0][seg_ch-1:0],
   output logic [bw_fph-1:0] ph_seg   [max_drift-1:0][zone_cham-1:0][seg_ch-1:0],
   output logic [seg_ch-1:0] ph_seg_v [max_drift-1:0][zone_cham-1:0],
   output logic [bw_th-1:0]  th_seg   [max_drift-1:0][zone_cham-1:0][zone_seg-1:0],
   output logic [3:0]        cpat_seg [max_drift-1:0][zone_cham-1:0][seg_ch-1:0],
   output logic              hist_full,
   output logic [seg_ch-1:0] dup_flag [zone_cham-1:0]
);

   localparam int PW = (max_drift > 1) ? $clog2(max_drift) : 1;
   localparam int FW = $clog2(max_drift + 1);
   localparam logic [PW-1:0] LAST_SLOT = PW'(max_drift - 1);
   localparam logic [FW-1:0] FILL_MAX  = FW'(max_drift);

   // Ring storage, indexed by slot
   logic [bw_fph-1:0] r_ph_mem   [max_drift-1:0][zone_cham-1:0][seg_ch-1:0];
   logic [seg_ch-1:0] r_v_mem    [max_drift-1:0][zone_cham-1:0];
   logic [bw_th-1:0]  r_th_mem   [max_drift-1:0][zone_cham-1:0][zone_seg-1:0];
   logic [3:0]        r_cpat_mem [max_drift-1:0][zone_cham-1:0][seg_ch-1:0];
   logic [PW-1:0]     r_wr_ptr;
   logic [FW-1:0]     r_fill;
   logic [seg_ch-1:0] r_dup_pend [zone_cham-1:0];

   logic [seg_ch-1:0] w_dup      [zone_cham-1:0];
   logic [seg_ch-1:0] w_store_v  [zone_cham-1:0];

   logic [bw_fph-1:0] w_ph_out   [max_drift-1:0][zone_cham-1:0][seg_ch-1:0];
   logic [seg_ch-1:0] w_v_out    [max_drift-1:0][zone_cham-1:0];
   logic [bw_th-1:0]  w_th_out   [max_drift-1:0][zone_cham-1:0][zone_seg-1:0];
   logic [3:0]        w_cpat_out [max_drift-1:0][zone_cham-1:0][seg_ch-1:0];

   // Slot holding the entry written d writes before the latest one.
   function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] ptr, input int d);
      int s;
      s = (int'(ptr) + 2 * max_drift - 1 - d) % max_drift;
      return PW'(s);
   endfunction

`ifdef SEG_HIST_DUP_SUPPRESS_EN
   logic [PW-1:0] w_prev_slot;
`endif

   // Duplicate detection against the newest stored slot, and the valid bits to store
   always_comb begin
`ifdef SEG_HIST_DUP_SUPPRESS_EN
      w_prev_slot = (r_wr_ptr == '0) ? LAST_SLOT : (r_wr_ptr - PW'(1));
`endif
      for (int j = 0; j < zone_cham; j++) begin
         w_dup[j] = '0;
`ifdef SEG_HIST_DUP_SUPPRESS_EN
         // Stored valid bits are cleared by reset/flush, so an empty history never matches.
         for (int k = 0; k < seg_ch; k++) begin
            for (int m = 0; m < seg_ch; m++) begin
               w_dup[j][k] = w_dup[j][k] |
                  (ph_v_in[j][k] & r_v_mem[w_prev_slot][j][m] &
                   (r_ph_mem[w_prev_slot][j][m] == ph_in[j][k]) &
                   (r_cpat_mem[w_prev_slot][j][m] == cpat_in[j][k]));
            end
         end
`endif
         w_store_v[j] = ph_v_in[j] & ~w_dup[j];
      end
   end

   // Ring write, pointer/fill bookkeeping and flush handling
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_fill   <= '0;
         for (int j = 0; j < zone_cham; j++) r_dup_pend[j] <= '0;
         for (int s = 0; s < max_drift; s++) begin
            for (int j = 0; j < zone_cham; j++) begin
               r_v_mem[s][j] <= '0;
               for (int k = 0; k < seg_ch; k++) begin
                  r_ph_mem[s][j][k]   <= '0;
                  r_cpat_mem[s][j][k] <= '0;
               end
               for (int t = 0; t < zone_seg; t++) r_th_mem[s][j][t] <= '0;
            end
         end
      end else if (flush) begin
         // Data bits may stay stale: valid bits alone gate them at the outputs.
         r_wr_ptr <= '0;
         r_fill   <= '0;
         for (int j = 0; j < zone_cham; j++) r_dup_pend[j] <= '0;
         for (int s = 0; s < max_drift; s++) begin
            for (int j = 0; j < zone_cham; j++) r_v_mem[s][j] <= '0;
         end
      end else if (bx_en) begin
         for (int j = 0; j < zone_cham; j++) begin
            r_v_mem[r_wr_ptr][j] <= w_store_v[j];
            r_dup_pend[j]        <= w_dup[j];
            for (int k = 0; k < seg_ch; k++) begin
               r_ph_mem[r_wr_ptr][j][k]   <= ph_in[j][k];
               r_cpat_mem[r_wr_ptr][j][k] <= cpat_in[j][k];
            end
            for (int t = 0; t < zone_seg; t++) r_th_mem[r_wr_ptr][j][t] <= th_in[j][t];
         end
         r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : (r_wr_ptr + PW'(1));
         r_fill   <= (r_fill == FILL_MAX) ? r_fill : (r_fill + FW'(1));
      end else begin
         // dup_flag is a single-update pulse, so the pending copy clears when idle.
         for (int j = 0; j < zone_cham; j++) r_dup_pend[j] <= '0;
      end
   end

   // History view: map age to slot, gate unwritten ages, mask invalid data
   always_comb begin
      for (int d = 0; d < max_drift; d++) begin
         for (int j = 0; j < zone_cham; j++) begin
            w_v_out[d][j] = (FW'(d) < r_fill) ? r_v_mem[slot_of(r_wr_ptr, d)][j] : '0;
            for (int k = 0; k < seg_ch; k++) begin
               w_ph_out[d][j][k]   = w_v_out[d][j][k] ? r_ph_mem[slot_of(r_wr_ptr, d)][j][k]   : '0;
               w_cpat_out[d][j][k] = w_v_out[d][j][k] ? r_cpat_mem[slot_of(r_wr_ptr, d)][j][k] : 4'd0;
            end
            for (int t = 0; t < zone_seg; t++) begin
               w_th_out[d][j][t] = (|w_v_out[d][j]) ? r_th_mem[slot_of(r_wr_ptr, d)][j][t] : '0;
            end
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_full <= 1'b0;
         for (int j = 0; j < zone_cham; j++) dup_flag[j] <= '0;
         for (int d = 0; d < max_drift; d++) begin
            for (int j = 0; j < zone_cham; j++) begin
               ph_seg_v[d][j] <= '0;
               for (int k = 0; k < seg_ch; k++) begin
                  ph_seg[d][j][k]   <= '0;
                  cpat_seg[d][j][k] <= '0;
               end
               for (int t = 0; t < zone_seg; t++) th_seg[d][j][t] <= '0;
            end
         end
      end else begin
         hist_full <= (r_fill == FILL_MAX);
         for (int j = 0; j < zone_cham; j++) dup_flag[j] <= r_dup_pend[j];
         for (int d = 0; d < max_drift; d++) begin
            for (int j = 0; j < zone_cham; j++) begin
               ph_seg_v[d][j] <= w_v_out[d][j];
               for (int k = 0; k < seg_ch; k++) begin
                  ph_seg[d][j][k]   <= w_ph_out[d][j][k];
                  cpat_seg[d][j][k] <= w_cpat_out[d][j][k];
               end
               for (int t = 0; t < zone_seg; t++) th_seg[d][j][t] <= w_th_out[d][j][t];
            end
         end
      end
   end

endmodule

// File: tb/tb_segment_history.sv
module tb_segment_history;

   logic        clk = 1'b0;
   logic        rst;
   logic        bx_en;
   logic        flush;
   logic [12:0] ph_in    [5:0][1:0];
   logic [1:0]  ph_v_in  [5:0];
   logic [6:0]  th_in    [5:0][1:0];
   logic [3:0]  cpat_in  [5:0][1:0];
   logic [12:0] ph_seg   [2:0][5:0][1:0];
   logic [1:0]  ph_seg_v [2:0][5:0];
   logic [6:0]  th_seg   [2:0][5:0][1:0];
   logic [3:0]  cpat_seg [2:0][5:0][1:0];
   logic        hist_full;
   logic [1:0]  dup_flag [5:0];

   int n_checks = 0;
   int n_errors = 0;

   segment_history dut (
      .clk(clk), .rst(rst), .bx_en(bx_en), .flush(flush),
      .ph_in(ph_in), .ph_v_in(ph_v_in), .th_in(th_in), .cpat_in(cpat_in),
      .ph_seg(ph_seg), .ph_seg_v(ph_seg_v), .th_seg(th_seg), .cpat_seg(cpat_seg),
      .hist_full(hist_full), .dup_flag(dup_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        be;
      logic        fl;
      logic [12:0] ph;
      logic        v;
      logic [12:0] e0;
      logic [12:0] e1;
      logic [12:0] e2;
      logic [2:0]  ev;
      logic        efull;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      for (int j = 0; j < 6; j++) begin
         ph_v_in[j] = 2'b00;
         for (int k = 0; k < 2; k++) begin
            ph_in[j][k]   = 13'd0;
            th_in[j][k]   = 7'd0;
            cpat_in[j][k] = 4'd0;
         end
      end
   endtask

   // Inputs are set by the caller; strobe across one edge, then wait for the output update.
   task automatic apply(input logic be, input logic fl);
      bx_en = be;
      flush = fl;
      @(negedge clk);
      bx_en = 1'b0;
      flush = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string name);
      logic nz;
      nz = hist_full;
      for (int d = 0; d < 3; d++) begin
         for (int j = 0; j < 6; j++) begin
            nz = nz | (|ph_seg_v[d][j]) | (|dup_flag[j]);
            for (int k = 0; k < 2; k++)
               nz = nz | (|ph_seg[d][j][k]) | (|th_seg[d][j][k]) | (|cpat_seg[d][j][k]);
         end
      end
      check(name, {31'd0, nz}, 32'd0);
   endtask

   initial begin
      //          be    fl    ph        v     e0        e1        e2        ev      full
      vecs[0] = '{1'b1, 1'b0, 13'd100, 1'b1, 13'd100, 13'd0,   13'd0,   3'b001, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 13'd200, 1'b1, 13'd200, 13'd100, 13'd0,   3'b011, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 13'd300, 1'b1, 13'd300, 13'd200, 13'd100, 3'b111, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 13'd400, 1'b1, 13'd400, 13'd300, 13'd200, 3'b111, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 13'd999, 1'b1, 13'd400, 13'd300, 13'd200, 3'b111, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 13'd555, 1'b1, 13'd0,   13'd0,   13'd0,   3'b000, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 13'd10,  1'b0, 13'd0,   13'd0,   13'd0,   3'b000, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 13'd20,  1'b1, 13'd20,  13'd0,   13'd0,   3'b001, 1'b0};

      rst   = 1'b1;
      bx_en = 1'b0;
      flush = 1'b0;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset_state");
      rst = 1'b0;
      @(negedge clk);

      // Shift, hold, flush collision, invalid write and fill gate on [*][0][0]
      for (int i = 0; i < 8; i++) begin
         clear_inputs();
         ph_in[0][0]   = vecs[i].ph;
         ph_v_in[0][0] = vecs[i].v;
         cpat_in[0][0] = 4'd3;
         apply(vecs[i].be, vecs[i].fl);
         check($sformatf("vec%0d_ph_d0", i), {19'd0, ph_seg[0][0][0]}, {19'd0, vecs[i].e0});
         check($sformatf("vec%0d_ph_d1", i), {19'd0, ph_seg[1][0][0]}, {19'd0, vecs[i].e1});
         check($sformatf("vec%0d_ph_d2", i), {19'd0, ph_seg[2][0][0]}, {19'd0, vecs[i].e2});
         check($sformatf("vec%0d_valid", i),
               {29'd0, ph_seg_v[2][0][0], ph_seg_v[1][0][0], ph_seg_v[0][0][0]},
               {29'd0, vecs[i].ev});
         check($sformatf("vec%0d_full", i), {31'd0, hist_full}, {31'd0, vecs[i].efull});
      end

      // Invalid masking: chamber 3 fully invalid, chamber 4 only segment 1 valid
      clear_inputs();
      ph_in[3][1] = 13'd1234; cpat_in[3][1] = 4'd5; th_in[3][0] = 7'd33; th_in[3][1] = 7'd44;
      ph_in[4][0] = 13'd321;  ph_in[4][1] = 13'd900; cpat_in[4][1] = 4'd9;
      th_in[4][0] = 7'd55;    th_in[4][1] = 7'd66;  ph_v_in[4] = 2'b10;
      apply(1'b1, 1'b0);
      check("mask_ph31",   {19'd0, ph_seg[0][3][1]},  32'd0);
      check("mask_cpat31", {28'd0, cpat_seg[0][3][1]}, 32'd0);
      check("mask_th30",   {25'd0, th_seg[0][3][0]},  32'd0);
      check("mask_th31",   {25'd0, th_seg[0][3][1]},  32'd0);
      check("mask_ph40",   {19'd0, ph_seg[0][4][0]},  32'd0);
      check("pass_ph41",   {19'd0, ph_seg[0][4][1]},  32'd900);
      check("pass_cpat41", {28'd0, cpat_seg[0][4][1]}, 32'd9);
      check("pass_th40",   {25'd0, th_seg[0][4][0]},  32'd55);
      check("pass_v4",     {30'd0, ph_seg_v[0][4]},   32'd2);

      // Duplicate: same phi/pattern in chamber 2 on consecutive crossings
      clear_inputs();
      ph_in[2][0] = 13'd640; cpat_in[2][0] = 4'd7; ph_v_in[2] = 2'b01;
      apply(1'b1, 1'b0);
      clear_inputs();
      ph_in[2][1] = 13'd640; cpat_in[2][1] = 4'd7; ph_v_in[2] = 2'b10; th_in[2][0] = 7'd12;
      apply(1'b1, 1'b0);
`ifdef SEG_HIST_DUP_SUPPRESS_EN
      check("dup_valid21", {31'd0, ph_seg_v[0][2][1]}, 32'd0);
      check("dup_flag21",  {31'd0, dup_flag[2][1]},    32'd1);
`else
      check("dup_valid21", {31'd0, ph_seg_v[0][2][1]}, 32'd1);
      check("dup_flag21",  {31'd0, dup_flag[2][1]},    32'd0);
`endif
      check("dup_flag20",  {31'd0, dup_flag[2][0]},    32'd0);
      check("dup_prev_v",  {31'd0, ph_seg_v[1][2][0]}, 32'd1);
      @(negedge clk);
      check("dup_pulse_end", {31'd0, dup_flag[2][1]}, 32'd0);

      // Mid-stream asynchronous reset after the history is full
      for (int i = 1; i <= 3; i++) begin
         clear_inputs();
         ph_in[0][0] = 13'(11 * i); ph_v_in[0] = 2'b01; th_in[0][0] = 7'd9;
         apply(1'b1, 1'b0);
      end
      check("pre_rst_full", {31'd0, hist_full}, 32'd1);
      check("pre_rst_ph",   {19'd0, ph_seg[0][0][0]}, 32'd33);
      #2 rst = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      ph_in[0][0] = 13'd77; ph_v_in[0] = 2'b01;
      apply(1'b1, 1'b0);
      check("post_rst_ph",  {19'd0, ph_seg[0][0][0]}, 32'd77);
      check("post_rst_v0",  {30'd0, ph_seg_v[0][0]},  32'd1);
      check("post_rst_v1",  {30'd0, ph_seg_v[1][0]},  32'd0);
      check("post_rst_full", {31'd0, hist_full},      32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
